// File: rtl/x_trig_capture.sv
// Channel-select trigger/capture stage: picks one delay-line tap word, detects a
// programmable edge, captures it, then holds off. X_TRIG_CAPTURE_ENCODE_EN adds o_taps.
module x_trig_capture #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS),
    parameter int HOLDOFF  = 4
) (
    input  logic                      i_clk,
    input  logic                      i_nrst,
    input  logic [CHANNELS*WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]          i_sel,
    input  logic [1:0]                i_mode,
    input  logic [WIDTH-1:0]          i_mask,
    input  logic                      i_arm,
    output logic [WIDTH-1:0]          o_data,
    output logic                      o_valid,
    output logic                      o_armed,
    output logic [15:0]               o_count
`ifdef X_TRIG_CAPTURE_ENCODE_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] o_taps
`endif
);

    localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sel_word;
    logic [WIDTH-1:0]   data_q, prev_q;
    logic [SEL_W-1:0]   sel_q;
    logic               prev_ok;
    logic               trig_raw, trig, capture;

    // Out-of-range selects fall through to channel 0.
    always_comb begin
        sel_word = i_data[WIDTH-1:0];
        for (int k = 1; k < CHANNELS; k++) begin
            if (i_sel == SEL_W'(k)) sel_word = i_data[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        trig_raw = 1'b0;
        case (i_mode)
            2'd0:    trig_raw = (&data_q) && !(&prev_q);
            2'd1:    trig_raw = (&prev_q) && !(&data_q);
            2'd2:    trig_raw = (data_q != prev_q);
            default: trig_raw = ((data_q & i_mask) == i_mask) && ((prev_q & i_mask) != i_mask);
        endcase
    end

    assign trig = trig_raw && prev_ok;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_arm) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                // A trigger wins over a simultaneous disarm.
                if (trig) begin
                    capture = 1'b1;
                    cnt_d   = CNT_W'(HOLDOFF - 1);
                    state_d = ST_HOLD;
                end else if (!i_arm) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) state_d = i_arm ? ST_ARMED : ST_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sample pipeline; prev_ok masks the compare straddling a channel switch.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            data_q  <= '0;
            prev_q  <= '0;
            sel_q   <= '0;
            prev_ok <= 1'b0;
        end else begin
            data_q  <= sel_word;
            sel_q   <= i_sel;
            prev_q  <= data_q;
            prev_ok <= (i_sel == sel_q);
        end
    end

    // o_valid is a one-cycle strobe, no backpressure: o_data is new exactly when it is high.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            o_data  <= '0;
            o_valid <= 1'b0;
            o_count <= '0;
        end else begin
            o_valid <= capture;
            if (capture) begin
                o_data <= data_q;
                if (o_count != 16'hFFFF) o_count <= o_count + 16'd1;
            end
        end
    end

    assign o_armed = (state_q == ST_ARMED);

`ifdef X_TRIG_CAPTURE_ENCODE_EN
    localparam int TAPS_W = $clog2(WIDTH + 1);

    function automatic logic [TAPS_W-1:0] popcount(input logic [WIDTH-1:0] w);
        logic [TAPS_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < WIDTH; i++) sum = sum + TAPS_W'(w[i]);
        return sum;
    endfunction

    always_ff @(posedge i_clk) begin
        if (!i_nrst)      o_taps <= '0;
        else if (capture) o_taps <= popcount(data_q);
    end
`endif

endmodule
